// File: rtl/nanci_pe_sequencer.sv
// Program-driven sequencer for a Nanci PE array: fetches 5-bit instruction words,
// then drives the neighbour-shift, sort and compute strobes and reports busy/done.
module nanci_pe_sequencer #(
  parameter int ADDR_WIDTH     = 3,
  parameter int SORT_CYCLES    = 1,
  parameter int COMPUTE_CYCLES = 1,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_stall,
  input  logic [4:0]            i_instr,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [1:0]            o_sel,
  output logic                  o_shift_en,
  output logic                  o_sort_en,
  output logic                  o_compute_en,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_SORT    = 3'd3;
  localparam logic [2:0] ST_COMPUTE = 3'd4;
  localparam logic [2:0] ST_NEXT    = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_SHIFT   = 2'b01;
  localparam logic [1:0] OP_SORT    = 2'b10;
  localparam logic [1:0] OP_COMPUTE = 2'b11;

  localparam logic [CNT_WIDTH-1:0]  SORT_LOAD    = CNT_WIDTH'(SORT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  COMPUTE_LOAD = CNT_WIDTH'(COMPUTE_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_LAST      = '1;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            sel_q, sel_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ir_last_q, ir_last_d;
  logic [1:0]            instr_op;

  assign instr_op = i_instr[4:3];

  // Next-state logic; a stall simply keeps every default (hold) value.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    ir_last_d = ir_last_q;
    if (!i_stall) begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d = ST_FETCH;
            pc_d    = '0;
          end
        end
        ST_FETCH: begin
          ir_last_d = i_instr[0];
          case (instr_op)
            OP_NOP:   state_d = ST_NEXT;
            OP_SHIFT: begin
              state_d = ST_SHIFT;
              sel_d   = i_instr[2:1];
            end
            OP_SORT: begin
              state_d = ST_SORT;
              cnt_d   = SORT_LOAD;
            end
            OP_COMPUTE: begin
              state_d = ST_COMPUTE;
              cnt_d   = COMPUTE_LOAD;
            end
            default: state_d = ST_NEXT;
          endcase
        end
        ST_SHIFT: state_d = ST_NEXT;
        ST_SORT, ST_COMPUTE: begin
          if (cnt_q == '0) state_d = ST_NEXT;
          else             cnt_d   = cnt_q - CNT_WIDTH'(1);
        end
        ST_NEXT: begin
          // The PC never wraps: the top address ends the run like an explicit last bit.
          if (ir_last_q || (pc_q == PC_LAST)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            pc_d    = pc_q + ADDR_WIDTH'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      sel_q   <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    ir_last_q <= ir_last_d;
  end

  // Strobes decode from registered state only; stall masks them without touching state.
  assign o_pc         = pc_q;
  assign o_sel        = sel_q;
  assign o_shift_en   = (state_q == ST_SHIFT)   && !i_stall;
  assign o_sort_en    = (state_q == ST_SORT)    && !i_stall;
  assign o_compute_en = (state_q == ST_COMPUTE) && !i_stall;
  assign o_done       = (state_q == ST_DONE)    && !i_stall;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nanci_pe_sequencer.sv
// Directed bench for nanci_pe_sequencer (SORT_CYCLES=3, COMPUTE_CYCLES=2) with a
// small program ROM; each scenario records a per-cycle trace and checks it inline.
module tb_nanci_pe_sequencer;

  logic       clk;
  logic       rst;
  logic       i_start;
  logic       i_stall;
  logic [4:0] i_instr;
  logic [2:0] o_pc;
  logic [1:0] o_sel;
  logic       o_shift_en, o_sort_en, o_compute_en, o_busy, o_done;

  logic [4:0] rom [8];

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] tr_pc   [32];
  logic [1:0] tr_sel  [32];
  logic       tr_sh   [32];
  logic       tr_so   [32];
  logic       tr_co   [32];
  logic       tr_busy [32];
  logic       tr_done [32];

  nanci_pe_sequencer #(
    .ADDR_WIDTH    (3),
    .SORT_CYCLES   (3),
    .COMPUTE_CYCLES(2),
    .CNT_WIDTH     (8)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_stall     (i_stall),
    .i_instr     (i_instr),
    .o_pc        (o_pc),
    .o_sel       (o_sel),
    .o_shift_en  (o_shift_en),
    .o_sort_en   (o_sort_en),
    .o_compute_en(o_compute_en),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  assign i_instr = rom[o_pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Cycle k of a run: inputs applied after the previous edge, outputs sampled at negedge.
  task automatic run_prog(input int n, input logic [31:0] st_m, input logic [31:0] stall_m,
                          input logic [31:0] rst_m);
    for (int k = 0; k < n; k++) begin
      i_start = st_m[k];
      i_stall = stall_m[k];
      rst     = ~rst_m[k];
      @(negedge clk);
      tr_pc[k]   = o_pc;
      tr_sel[k]  = o_sel;
      tr_sh[k]   = o_shift_en;
      tr_so[k]   = o_sort_en;
      tr_co[k]   = o_compute_en;
      tr_busy[k] = o_busy;
      tr_done[k] = o_done;
      @(posedge clk);
      #1;
    end
    i_start = 1'b0;
    i_stall = 1'b0;
    rst     = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_start = 1'b0; i_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (o_pc !== 3'd0) begin n_fail++; $display("FAIL rst_pc got=%0d exp=0", o_pc); end
    n_tests++; if (o_sel !== 2'b00) begin n_fail++; $display("FAIL rst_sel got=%b exp=00", o_sel); end
    n_tests++; if ({o_shift_en, o_sort_en, o_compute_en} !== 3'b000) begin
      n_fail++; $display("FAIL rst_enables got=%b exp=000", {o_shift_en, o_sort_en, o_compute_en}); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
    n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", o_done); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got=%b exp=0", o_busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_shift();
    logic e_busy, e_done, e_sh; logic [1:0] e_sel;
    for (int i = 0; i < 8; i++) rom[i] = 5'b00000;
    rom[0] = 5'b01011;  // SHIFT R, last
    run_prog(7, 32'h1, 32'h0, 32'h0);
    for (int k = 0; k < 7; k++) begin
      e_busy = (k >= 1 && k <= 4);
      e_done = (k == 4);
      e_sh   = (k == 2);
      e_sel  = (k >= 2) ? 2'b01 : 2'b00;
      n_tests++; if (tr_busy[k] !== e_busy) begin n_fail++; $display("FAIL shift_busy cyc=%0d got=%b exp=%b", k, tr_busy[k], e_busy); end
      n_tests++; if (tr_done[k] !== e_done) begin n_fail++; $display("FAIL shift_done cyc=%0d got=%b exp=%b", k, tr_done[k], e_done); end
      n_tests++; if (tr_sh[k] !== e_sh) begin n_fail++; $display("FAIL shift_en cyc=%0d got=%b exp=%b", k, tr_sh[k], e_sh); end
      n_tests++; if (tr_sel[k] !== e_sel) begin n_fail++; $display("FAIL shift_sel cyc=%0d got=%b exp=%b", k, tr_sel[k], e_sel); end
      n_tests++; if ({tr_so[k], tr_co[k]} !== 2'b00) begin n_fail++; $display("FAIL shift_other_en cyc=%0d got=%b exp=00", k, {tr_so[k], tr_co[k]}); end
      n_tests++; if (tr_pc[k] !== 3'd0) begin n_fail++; $display("FAIL shift_pc cyc=%0d got=%0d exp=0", k, tr_pc[k]); end
    end
  endtask

  task automatic test_sort_compute();
    logic e_busy, e_done, e_so, e_co; logic [2:0] e_pc;
    rom[0] = 5'b10000;  // SORT
    rom[1] = 5'b11001;  // COMPUTE, last
    run_prog(13, 32'h1, 32'h0, 32'h0);
    for (int k = 0; k < 13; k++) begin
      e_busy = (k >= 1 && k <= 10);
      e_done = (k == 10);
      e_so   = (k >= 2 && k <= 4);
      e_co   = (k == 7 || k == 8);
      e_pc   = (k <= 5) ? 3'd0 : 3'd1;
      n_tests++; if (tr_busy[k] !== e_busy) begin n_fail++; $display("FAIL sc_busy cyc=%0d got=%b exp=%b", k, tr_busy[k], e_busy); end
      n_tests++; if (tr_done[k] !== e_done) begin n_fail++; $display("FAIL sc_done cyc=%0d got=%b exp=%b", k, tr_done[k], e_done); end
      n_tests++; if (tr_so[k] !== e_so) begin n_fail++; $display("FAIL sc_sort_en cyc=%0d got=%b exp=%b", k, tr_so[k], e_so); end
      n_tests++; if (tr_co[k] !== e_co) begin n_fail++; $display("FAIL sc_compute_en cyc=%0d got=%b exp=%b", k, tr_co[k], e_co); end
      n_tests++; if (tr_sh[k] !== 1'b0) begin n_fail++; $display("FAIL sc_shift_en cyc=%0d got=%b exp=0", k, tr_sh[k]); end
      n_tests++; if (tr_pc[k] !== e_pc) begin n_fail++; $display("FAIL sc_pc cyc=%0d got=%0d exp=%0d", k, tr_pc[k], e_pc); end
      n_tests++; if (tr_sel[k] !== 2'b01) begin n_fail++; $display("FAIL sc_sel_hold cyc=%0d got=%b exp=01", k, tr_sel[k]); end
    end
  endtask

  task automatic test_nop_run();
    logic e_busy, e_done; logic [2:0] e_pc;
    for (int i = 0; i < 8; i++) rom[i] = 5'b00000;
    run_prog(20, 32'h1, 32'h0, 32'h0);
    for (int k = 0; k < 20; k++) begin
      e_busy = (k >= 1 && k <= 17);
      e_done = (k == 17);
      e_pc   = (k == 0) ? 3'd1 : (k <= 16) ? 3'((k - 1) / 2) : 3'd7;
      n_tests++; if (tr_busy[k] !== e_busy) begin n_fail++; $display("FAIL nop_busy cyc=%0d got=%b exp=%b", k, tr_busy[k], e_busy); end
      n_tests++; if (tr_done[k] !== e_done) begin n_fail++; $display("FAIL nop_done cyc=%0d got=%b exp=%b", k, tr_done[k], e_done); end
      n_tests++; if (tr_pc[k] !== e_pc) begin n_fail++; $display("FAIL nop_pc cyc=%0d got=%0d exp=%0d", k, tr_pc[k], e_pc); end
      n_tests++; if ({tr_sh[k], tr_so[k], tr_co[k]} !== 3'b000) begin
        n_fail++; $display("FAIL nop_enables cyc=%0d got=%b exp=000", k, {tr_sh[k], tr_so[k], tr_co[k]}); end
    end
  endtask

  task automatic test_stall();
    logic e_busy, e_done, e_so, e_sh; logic [2:0] e_pc; logic [1:0] e_sel;
    int so_total;
    // SORT (3 cycles) stalled for 2 cycles after its first cycle.
    for (int i = 0; i < 8; i++) rom[i] = 5'b00000;
    rom[0] = 5'b10001;
    run_prog(10, 32'h1, 32'h18, 32'h0);
    so_total = 0;
    for (int k = 0; k < 10; k++) begin
      e_busy = (k >= 1 && k <= 8);
      e_done = (k == 8);
      e_so   = (k == 2 || k == 5 || k == 6);
      e_pc   = (k == 0) ? 3'd7 : 3'd0;
      if (tr_so[k] === 1'b1) so_total++;
      n_tests++; if (tr_busy[k] !== e_busy) begin n_fail++; $display("FAIL stall_busy cyc=%0d got=%b exp=%b", k, tr_busy[k], e_busy); end
      n_tests++; if (tr_done[k] !== e_done) begin n_fail++; $display("FAIL stall_done cyc=%0d got=%b exp=%b", k, tr_done[k], e_done); end
      n_tests++; if (tr_so[k] !== e_so) begin n_fail++; $display("FAIL stall_sort_en cyc=%0d got=%b exp=%b", k, tr_so[k], e_so); end
      n_tests++; if (tr_pc[k] !== e_pc) begin n_fail++; $display("FAIL stall_pc cyc=%0d got=%0d exp=%0d", k, tr_pc[k], e_pc); end
    end
    n_tests++; if (so_total != 3) begin n_fail++; $display("FAIL stall_sort_total got=%0d exp=3", so_total); end
    // SHIFT L with a stall landing on DONE: the done pulse slides one cycle later.
    rom[0] = 5'b01001;
    run_prog(7, 32'h1, 32'h10, 32'h0);
    for (int k = 0; k < 7; k++) begin
      e_busy = (k >= 1 && k <= 5);
      e_done = (k == 5);
      e_sh   = (k == 2);
      e_sel  = (k >= 2) ? 2'b00 : 2'b01;
      n_tests++; if (tr_busy[k] !== e_busy) begin n_fail++; $display("FAIL stdone_busy cyc=%0d got=%b exp=%b", k, tr_busy[k], e_busy); end
      n_tests++; if (tr_done[k] !== e_done) begin n_fail++; $display("FAIL stdone_done cyc=%0d got=%b exp=%b", k, tr_done[k], e_done); end
      n_tests++; if (tr_sh[k] !== e_sh) begin n_fail++; $display("FAIL stdone_shift_en cyc=%0d got=%b exp=%b", k, tr_sh[k], e_sh); end
      n_tests++; if (tr_sel[k] !== e_sel) begin n_fail++; $display("FAIL stdone_sel cyc=%0d got=%b exp=%b", k, tr_sel[k], e_sel); end
    end
    // Start together with stall in IDLE is dropped.
    run_prog(3, 32'h1, 32'h1, 32'h0);
    for (int k = 1; k < 3; k++) begin
      n_tests++; if (tr_busy[k] !== 1'b0) begin n_fail++; $display("FAIL stall_start_busy cyc=%0d got=%b exp=0", k, tr_busy[k]); end
    end
  endtask

  task automatic test_start_busy_reset();
    logic e_busy, e_so, e_sh; logic [2:0] e_pc; logic [1:0] e_sel;
    rom[0] = 5'b01100;  // SHIFT U
    rom[1] = 5'b10001;  // SORT, last
    // start held through cycle 5, reset low in cycle 6 (second SORT cycle)
    run_prog(11, 32'h3F, 32'h0, 32'h40);
    for (int k = 0; k < 11; k++) begin
      e_busy = (k >= 1 && k <= 6);
      e_so   = (k == 5 || k == 6);
      e_sh   = (k == 2);
      e_pc   = (k >= 4 && k <= 6) ? 3'd1 : 3'd0;
      e_sel  = (k >= 2 && k <= 6) ? 2'b10 : 2'b00;
      n_tests++; if (tr_busy[k] !== e_busy) begin n_fail++; $display("FAIL abort_busy cyc=%0d got=%b exp=%b", k, tr_busy[k], e_busy); end
      n_tests++; if (tr_done[k] !== 1'b0) begin n_fail++; $display("FAIL abort_done cyc=%0d got=%b exp=0", k, tr_done[k]); end
      n_tests++; if (tr_so[k] !== e_so) begin n_fail++; $display("FAIL abort_sort_en cyc=%0d got=%b exp=%b", k, tr_so[k], e_so); end
      n_tests++; if (tr_sh[k] !== e_sh) begin n_fail++; $display("FAIL abort_shift_en cyc=%0d got=%b exp=%b", k, tr_sh[k], e_sh); end
      n_tests++; if (tr_pc[k] !== e_pc) begin n_fail++; $display("FAIL abort_pc cyc=%0d got=%0d exp=%0d", k, tr_pc[k], e_pc); end
      n_tests++; if (tr_sel[k] !== e_sel) begin n_fail++; $display("FAIL abort_sel cyc=%0d got=%b exp=%b", k, tr_sel[k], e_sel); end
    end
    // Fresh run after the abort starts from address 0.
    rom[0] = 5'b00000;  // NOP
    rom[1] = 5'b01111;  // SHIFT D, last
    run_prog(8, 32'h1, 32'h0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      e_busy = (k >= 1 && k <= 6);
      e_sh   = (k == 4);
      e_pc   = (k <= 2) ? 3'd0 : 3'd1;
      e_sel  = (k >= 4) ? 2'b11 : 2'b00;
      n_tests++; if (tr_busy[k] !== e_busy) begin n_fail++; $display("FAIL rerun_busy cyc=%0d got=%b exp=%b", k, tr_busy[k], e_busy); end
      n_tests++; if (tr_done[k] !== (k == 6)) begin n_fail++; $display("FAIL rerun_done cyc=%0d got=%b exp=%b", k, tr_done[k], (k == 6)); end
      n_tests++; if (tr_sh[k] !== e_sh) begin n_fail++; $display("FAIL rerun_shift_en cyc=%0d got=%b exp=%b", k, tr_sh[k], e_sh); end
      n_tests++; if (tr_pc[k] !== e_pc) begin n_fail++; $display("FAIL rerun_pc cyc=%0d got=%0d exp=%0d", k, tr_pc[k], e_pc); end
      n_tests++; if (tr_sel[k] !== e_sel) begin n_fail++; $display("FAIL rerun_sel cyc=%0d got=%b exp=%b", k, tr_sel[k], e_sel); end
    end
  endtask

  initial begin
    rst = 1'b0; i_start = 1'b0; i_stall = 1'b0;
    for (int i = 0; i < 8; i++) rom[i] = 5'b00000;
    test_reset();
    test_shift();
    test_sort_compute();
    test_nop_run();
    test_stall();
    test_start_busy_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
